// File: rtl/gpc_4t_pkg.sv
// gpc_4t_pkg: shared request/tag types for the GPC memory arbiter.
package gpc_4t_pkg;

    localparam int PKG_ADDR_W = 32;
    localparam int PKG_DATA_W = 32;
    localparam int PKG_BE_W   = PKG_DATA_W / 8;

    typedef struct packed {
        logic                  wr;
        logic [PKG_ADDR_W-1:0] adrs;
        logic [PKG_DATA_W-1:0] data;
        logic [PKG_BE_W-1:0]   byte_en;
    } t_mem_req;

    typedef enum logic {SRC_CORE = 1'b0, SRC_MMIO = 1'b1} t_src;

    typedef struct packed {
        logic valid;
        t_src src;
    } t_rd_tag;

endpackage

// File: rtl/gpc_sync_fifo.sv
// gpc_sync_fifo: synchronous FIFO with an extra pointer bit for full/empty detection.
module gpc_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;

    assign empty = wp == rp;
    assign full  = {~wp[AW], wp[AW-1:0]} == rp;
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            mem[wp[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + PW'(push);
            rp <= rp + PW'(pop);
        end
    end
endmodule

// File: rtl/gpc_mem_arb.sv
// gpc_mem_arb: shares one memory port between the core pipeline and a queued MMIO
// requester; the core wins unless an MMIO request has starved for STARVE_MAX cycles.
module gpc_mem_arb
    import gpc_4t_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REQ_DEPTH  = 4,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8,
    localparam int BE_W      = DATA_W / 8
) (
    input  logic              QClk,
    input  logic              RstQnnnH,
    input  logic              CoreRdQ103H,
    input  logic              CoreWrQ103H,
    input  logic [ADDR_W-1:0] CoreAdrsQ103H,
    input  logic [DATA_W-1:0] CoreWrDataQ103H,
    input  logic [BE_W-1:0]   CoreByteEnQ103H,
    output logic              CoreStallQ103H,
    output logic [DATA_W-1:0] CoreRdDataQ104H,
    input  logic              MmioReqValid,
    output logic              MmioReqReady,
    input  logic              MmioReqWr,
    input  logic [ADDR_W-1:0] MmioReqAdrs,
    input  logic [DATA_W-1:0] MmioReqData,
    input  logic [BE_W-1:0]   MmioReqByteEn,
    output logic              MmioRspValid,
    output logic [DATA_W-1:0] MmioRspData,
    output logic              MemRd,
    output logic              MemWr,
    output logic [ADDR_W-1:0] MemAdrs,
    output logic [DATA_W-1:0] MemWrData,
    output logic [BE_W-1:0]   MemByteEn,
    input  logic [DATA_W-1:0] MemRdData
);
    localparam int         RW        = 1 + ADDR_W + DATA_W + BE_W;
    localparam logic [7:0] STARVE_TH = 8'(STARVE_MAX);

    logic [RW-1:0]     head;
    logic              head_wr;
    logic [ADDR_W-1:0] head_adrs;
    logic [DATA_W-1:0] head_data;
    logic [BE_W-1:0]   head_be;
    logic              fifo_full, fifo_empty, push;
    logic              core_act, core_gnt, mmio_gnt, stall, core_hit;
    logic [7:0]        wait_cnt;
    logic [DATA_W-1:0] core_rd_q;
    t_rd_tag           tag_in;
    t_rd_tag           tag_q [RD_LAT];

    assign MmioReqReady = !fifo_full && !RstQnnnH;
    assign push         = MmioReqValid && MmioReqReady;
    assign {head_wr, head_adrs, head_data, head_be} = head;

    gpc_sync_fifo #(.W(RW), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk   (QClk),
        .rst   (RstQnnnH),
        .push  (push),
        .pop   (mmio_gnt),
        .din   ({MmioReqWr, MmioReqAdrs, MmioReqData, MmioReqByteEn}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A stall hands exactly one slot to MMIO; the grant clears wait_cnt so it cannot repeat.
    assign core_act       = CoreRdQ103H || CoreWrQ103H;
    assign stall          = !RstQnnnH && core_act && !fifo_empty && wait_cnt >= STARVE_TH;
    assign core_gnt       = !RstQnnnH && core_act && !stall;
    assign mmio_gnt       = !RstQnnnH && !fifo_empty && (!core_act || stall);
    assign CoreStallQ103H = stall;

    assign MemWr     = core_gnt ? CoreWrQ103H : mmio_gnt && head_wr;
    assign MemRd     = core_gnt ? CoreRdQ103H && !CoreWrQ103H : mmio_gnt && !head_wr;
    assign MemAdrs   = core_gnt ? CoreAdrsQ103H : head_adrs;
    assign MemWrData = core_gnt ? CoreWrDataQ103H : head_data;
    assign MemByteEn = core_gnt ? CoreByteEnQ103H : head_be;

    assign tag_in          = '{valid: MemRd, src: mmio_gnt ? SRC_MMIO : SRC_CORE};
    assign core_hit        = !RstQnnnH && tag_q[RD_LAT-1].valid && tag_q[RD_LAT-1].src == SRC_CORE;
    assign MmioRspValid    = !RstQnnnH && tag_q[RD_LAT-1].valid && tag_q[RD_LAT-1].src == SRC_MMIO;
    assign MmioRspData     = MemRdData;
    assign CoreRdDataQ104H = core_hit ? MemRdData : core_rd_q;

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            wait_cnt  <= '0;
            core_rd_q <= '0;
            for (int i = 0; i < RD_LAT; i++)
                tag_q[i] <= '0;
        end else begin
            wait_cnt <= (fifo_empty || mmio_gnt) ? '0 : wait_cnt + {7'd0, wait_cnt != 8'hFF};
            if (core_hit)
                core_rd_q <= MemRdData;
            tag_q[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++)
                tag_q[i] <= tag_q[i-1];
        end
    end
endmodule

// File: tb/tb_gpc_mem_arb.sv
// tb_gpc_mem_arb: directed bench for gpc_mem_arb; a second instance with RD_LAT=3
// shares all stimulus and is used for the in-flight reset scenario.
module tb_gpc_mem_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        core_rd, core_wr;
    logic [31:0] core_adrs, core_wdata;
    logic [3:0]  core_be;
    logic        m_valid, m_wr;
    logic [31:0] m_adrs, m_data;
    logic [3:0]  m_be;

    logic        stall, ready, rsp_valid, mem_rd, mem_wr;
    logic [31:0] rsp_data, mem_adrs, mem_wdata, rd_data, core_rdata;
    logic [3:0]  mem_be;
    logic        stall3, ready3, rsp_valid3, mem_rd3, mem_wr3;
    logic [31:0] rsp_data3, mem_adrs3, mem_wdata3, rd_data3, core_rdata3;
    logic [3:0]  mem_be3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gpc_mem_arb u1 (
        .QClk(clk), .RstQnnnH(rst),
        .CoreRdQ103H(core_rd), .CoreWrQ103H(core_wr), .CoreAdrsQ103H(core_adrs),
        .CoreWrDataQ103H(core_wdata), .CoreByteEnQ103H(core_be),
        .CoreStallQ103H(stall), .CoreRdDataQ104H(core_rdata),
        .MmioReqValid(m_valid), .MmioReqReady(ready), .MmioReqWr(m_wr),
        .MmioReqAdrs(m_adrs), .MmioReqData(m_data), .MmioReqByteEn(m_be),
        .MmioRspValid(rsp_valid), .MmioRspData(rsp_data),
        .MemRd(mem_rd), .MemWr(mem_wr), .MemAdrs(mem_adrs), .MemWrData(mem_wdata),
        .MemByteEn(mem_be), .MemRdData(rd_data)
    );

    gpc_mem_arb #(.RD_LAT(3)) u3 (
        .QClk(clk), .RstQnnnH(rst),
        .CoreRdQ103H(core_rd), .CoreWrQ103H(core_wr), .CoreAdrsQ103H(core_adrs),
        .CoreWrDataQ103H(core_wdata), .CoreByteEnQ103H(core_be),
        .CoreStallQ103H(stall3), .CoreRdDataQ104H(core_rdata3),
        .MmioReqValid(m_valid), .MmioReqReady(ready3), .MmioReqWr(m_wr),
        .MmioReqAdrs(m_adrs), .MmioReqData(m_data), .MmioReqByteEn(m_be),
        .MmioRspValid(rsp_valid3), .MmioRspData(rsp_data3),
        .MemRd(mem_rd3), .MemWr(mem_wr3), .MemAdrs(mem_adrs3), .MemWrData(mem_wdata3),
        .MemByteEn(mem_be3), .MemRdData(rd_data3)
    );

    // Word memory: word i starts as A5A5_0000 | i; written only by u1's port.
    logic [31:0] mem [1024];
    logic [31:0] d3 [3];
    logic        init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++)
                mem[i] <= {16'hA5A5, 6'd0, 10'(i)};
            init_done <= 1'b1;
        end else if (mem_wr) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b])
                    mem[mem_adrs[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        rd_data <= mem[mem_adrs[11:2]];
        d3[0]   <= mem[mem_adrs3[11:2]];
        d3[1]   <= d3[0];
        d3[2]   <= d3[1];
    end
    assign rd_data3 = d3[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; core_rd = 1'b1; core_adrs = 32'h100; m_valid = 1'b1; m_wr = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (ready3 !== 1'b0) begin errors++; $display("FAIL reset_ready3: got %b expected 0", ready3); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if ({mem_rd, mem_wr} !== 2'b00) begin errors++; $display("FAIL reset_mem: got %b expected 00", {mem_rd, mem_wr}); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %b expected 0", rsp_valid); end
        checks++; if (core_rdata !== 32'h0) begin errors++; $display("FAIL reset_core_rdata: got %h expected 0", core_rdata); end
        tick();
        rst = 1'b0; m_valid = 1'b0; core_rd = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", ready); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b expected 0", mem_rd); end
    endtask

    task automatic test_core_read();
        tick();
        core_rd = 1'b1; core_adrs = 32'h100;
        @(negedge clk);
        checks++; if ({mem_rd, mem_wr, stall} !== 3'b100) begin errors++; $display("FAIL core_rd_ctl: got %b expected 100", {mem_rd, mem_wr, stall}); end
        checks++; if (mem_adrs !== 32'h100) begin errors++; $display("FAIL core_rd_adrs: got %h expected 100", mem_adrs); end
        tick();
        core_rd = 1'b0;
        @(negedge clk);
        checks++; if (core_rdata !== 32'hA5A5_0040) begin errors++; $display("FAIL core_rd_data: got %h expected a5a50040", core_rdata); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL core_rd_idle: got %b expected 0", mem_rd); end
        tick();
        @(negedge clk);
        checks++; if (core_rdata !== 32'hA5A5_0040) begin errors++; $display("FAIL core_rd_hold: got %h expected a5a50040", core_rdata); end
    endtask

    task automatic test_mmio_write();
        tick();
        m_valid = 1'b1; m_wr = 1'b1; m_adrs = 32'h200; m_data = 32'hDEAD_BEEF; m_be = 4'hF;
        @(negedge clk);
        checks++; if ({ready, mem_wr} !== 2'b10) begin errors++; $display("FAIL mmio_accept: got %b expected 10", {ready, mem_wr}); end
        tick();
        m_valid = 1'b0;
        @(negedge clk);
        checks++; if ({mem_wr, mem_rd, rsp_valid} !== 3'b100) begin errors++; $display("FAIL mmio_wr_ctl: got %b expected 100", {mem_wr, mem_rd, rsp_valid}); end
        checks++; if ({mem_adrs, mem_wdata, mem_be} !== {32'h200, 32'hDEAD_BEEF, 4'hF}) begin
            errors++; $display("FAIL mmio_wr_bus: got %h %h %h expected 200 deadbeef f", mem_adrs, mem_wdata, mem_be); end
        tick();
        @(negedge clk);
        checks++; if ({mem_wr, rsp_valid} !== 2'b00) begin errors++; $display("FAIL mmio_wr_done: got %b expected 00", {mem_wr, rsp_valid}); end
        tick();
        m_valid = 1'b1; m_wr = 1'b0; m_adrs = 32'h200;
        tick();
        m_valid = 1'b0;
        @(negedge clk);
        checks++; if ({mem_rd, mem_adrs} !== {1'b1, 32'h200}) begin errors++; $display("FAIL mmio_rd_issue: got %b %h expected 1 200", mem_rd, mem_adrs); end
        tick();
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL mmio_rd_rsp: got %b %h expected 1 deadbeef", rsp_valid, rsp_data); end
        tick();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mmio_rsp_pulse: got %b expected 0", rsp_valid); end
        tick();
        core_wr = 1'b1; core_adrs = 32'h200; core_wdata = 32'h1122_3344; core_be = 4'h3;
        @(negedge clk);
        checks++; if ({mem_wr, mem_rd, mem_wdata, mem_be} !== {2'b10, 32'h1122_3344, 4'h3}) begin
            errors++; $display("FAIL core_wr_bus: got %b%b %h %h expected 10 11223344 3", mem_wr, mem_rd, mem_wdata, mem_be); end
        tick();
        core_wr = 1'b0; core_rd = 1'b1;
        tick();
        core_rd = 1'b0;
        @(negedge clk);
        checks++; if (core_rdata !== 32'hDEAD_3344) begin errors++; $display("FAIL core_be_merge: got %h expected dead3344", core_rdata); end
    endtask

    task automatic test_starve();
        int nst = 0, scyc = -1, nrsp = 0;
        logic prev = 1'b0;
        tick();
        core_rd = 1'b1; core_adrs = 32'h104; m_valid = 1'b1; m_wr = 1'b0; m_adrs = 32'h300;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall) begin
                nst++; scyc = i;
                checks++; if ({mem_rd, mem_adrs} !== {1'b1, 32'h300}) begin errors++; $display("FAIL starve_mmio_gnt: got %b %h expected 1 300", mem_rd, mem_adrs); end
            end
            if (prev) begin
                checks++; if ({stall, mem_rd, mem_adrs} !== {2'b01, 32'h104}) begin errors++; $display("FAIL starve_core_next: got %b%b %h expected 01 104", stall, mem_rd, mem_adrs); end
            end
            if (rsp_valid) nrsp++;
            if (i == 5) begin
                checks++; if (core_rdata !== 32'hA5A5_0041) begin errors++; $display("FAIL starve_core_data: got %h expected a5a50041", core_rdata); end
            end
            if (i == 10) begin
                checks++; if ({rsp_valid, rsp_data, core_rdata} !== {1'b1, 32'hA5A5_00C0, 32'hA5A5_0041}) begin
                    errors++; $display("FAIL starve_rsp: got %b %h %h expected 1 a5a500c0 a5a50041", rsp_valid, rsp_data, core_rdata); end
            end
            prev = stall;
            tick();
            if (i == 0) m_valid = 1'b0;
        end
        core_rd = 1'b0;
        checks++; if (nst !== 1) begin errors++; $display("FAIL starve_count: got %0d expected 1", nst); end
        checks++; if (scyc !== 9) begin errors++; $display("FAIL starve_cycle: got %0d expected 9", scyc); end
        checks++; if (nrsp !== 1) begin errors++; $display("FAIL starve_rsp_count: got %0d expected 1", nrsp); end
    endtask

    task automatic test_fifo_full();
        int p = 0, wi = 0, acc4 = -1, pop0 = -1, both = 0;
        tick();
        for (int i = 0; i < 30; i++) begin
            m_valid = p < 5; m_wr = 1'b1; m_adrs = 32'h400 + 32'(p * 4); m_data = 32'(p); m_be = 4'hF;
            core_rd = i < 12; core_adrs = 32'h104;
            @(negedge clk);
            if (mem_rd && mem_wr) both++;
            if (i == 4) begin
                checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready: got %b expected 0", ready); end
            end
            if (i == 10) begin
                checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fifo_after_pop_ready: got %b expected 1", ready); end
            end
            if (mem_wr) begin
                if (wi == 0) pop0 = i;
                checks++; if ({mem_adrs, mem_wdata} !== {32'h400 + 32'(wi * 4), 32'(wi)}) begin
                    errors++; $display("FAIL fifo_order: got %h %h expected %h %h", mem_adrs, mem_wdata, 32'h400 + 32'(wi * 4), 32'(wi)); end
                wi++;
            end
            if (m_valid && ready) begin
                if (p == 4) acc4 = i;
                p++;
            end
            tick();
        end
        m_valid = 1'b0; core_rd = 1'b0;
        checks++; if (both !== 0) begin errors++; $display("FAIL rd_wr_exclusive: got %0d expected 0", both); end
        checks++; if (pop0 !== 9) begin errors++; $display("FAIL fifo_first_pop: got %0d expected 9", pop0); end
        checks++; if (acc4 !== 10) begin errors++; $display("FAIL fifo_fifth_accept: got %0d expected 10", acc4); end
        checks++; if (wi !== 5) begin errors++; $display("FAIL fifo_drained: got %0d expected 5", wi); end
    endtask

    task automatic test_reset_inflight();
        int nrsp = 0;
        tick();
        m_valid = 1'b1; m_wr = 1'b0; m_adrs = 32'h300; m_be = 4'hF;
        tick();
        m_valid = 1'b0;
        @(negedge clk);
        checks++; if ({mem_rd3, mem_adrs3} !== {1'b1, 32'h300}) begin errors++; $display("FAIL inflight_issue: got %b %h expected 1 300", mem_rd3, mem_adrs3); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({ready3, mem_rd3, mem_wr3, stall3, rsp_valid3} !== 5'b0) begin
            errors++; $display("FAIL inflight_reset_outs: got %b expected 00000", {ready3, mem_rd3, mem_wr3, stall3, rsp_valid3}); end
        tick();
        @(negedge clk);
        checks++; if ({core_rdata3, core_rdata} !== 64'h0) begin errors++; $display("FAIL inflight_reset_rdata: got %h %h expected 0 0", core_rdata3, core_rdata); end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid3 || rsp_valid) nrsp++;
            tick();
        end
        checks++; if (nrsp !== 0) begin errors++; $display("FAIL inflight_discarded: got %0d expected 0", nrsp); end
        m_valid = 1'b1; m_adrs = 32'h200;
        tick();
        m_valid = 1'b0;
        @(negedge clk);
        checks++; if ({mem_rd3, mem_adrs3} !== {1'b1, 32'h200}) begin errors++; $display("FAIL post_reset_issue: got %b %h expected 1 200", mem_rd3, mem_adrs3); end
        for (int k = 2; k <= 4; k++) begin
            tick();
            @(negedge clk);
            if (k < 4) begin
                checks++; if (rsp_valid3 !== 1'b0) begin errors++; $display("FAIL post_reset_early_rsp%0d: got %b expected 0", k, rsp_valid3); end
            end else begin
                checks++; if ({rsp_valid3, rsp_data3} !== {1'b1, 32'hDEAD_3344}) begin
                    errors++; $display("FAIL post_reset_rsp: got %b %h expected 1 dead3344", rsp_valid3, rsp_data3); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; core_rd = 1'b0; core_wr = 1'b0; core_adrs = '0; core_wdata = '0; core_be = '0;
        m_valid = 1'b0; m_wr = 1'b0; m_adrs = '0; m_data = '0; m_be = '0;
        test_reset();
        test_core_read();
        test_mmio_write();
        test_starve();
        test_fifo_full();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
